wb_regfile_stage: RTL

- Write-back stage: consumes MEM/WB pipeline register outputs, selects the write-back value, and commits it into a 32x32 general-purpose register file.
- Provides the two asynchronous read ports used by the decode stage.
- Exports the write-back bus to the EX forwarding unit.
- Keeps a count of retired register writes for debug and performance.

---
 rtl/wb_regfile_stage.sv | 95 +++++++++
 1 files changed

// File: rtl/wb_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_stage
// Purpose  : Write-back stage. Selects the MEM/WB write-back value, commits it
//            into a 32x32 general-purpose register file, serves two
//            asynchronous decode read ports, exports the write-back bus to the
//            forwarding unit and counts retired register writes.
// Option   : WB_BYPASS_EN - when defined, both read ports see a same-cycle
//            write (write-through bypass). When undefined, reads return the
//            stored contents only.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] ReadData_in,
  input  logic [4:0]        WriteReg_in,
  input  logic [1:0]        WBControl_in,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wb_count
);

  // Field positions inside the MEM/WB control bundle
  localparam int C_REGWRITE_BIT = 1;
  localparam int C_MEMTOREG_BIT = 0;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  wb_count_q;
  logic [CNT_W-1:0]  wb_count_d;

  // Write-back bus: value select and effective enable ($0 is never written)
  always_comb begin
    wb_addr = WriteReg_in;
    wb_data = WBControl_in[C_MEMTOREG_BIT] ? ReadData_in : ALUResult_in;
    wb_we   = WBControl_in[C_REGWRITE_BIT] && (WriteReg_in != 5'd0);
  end

  // Register file commit; reset clears every entry immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Retired-write counter next state; wraps naturally modulo 2^CNT_W
  always_comb begin
    wb_count_d = wb_count_q;
    if (wb_we) begin
      wb_count_d = wb_count_q + CNT_W'(1);
    end
  end

  // Retired-write counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;

  // Asynchronous read ports; address 0 is hard-wired to zero
  always_comb begin
    rs_data = (rs_addr == 5'd0) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == 5'd0) ? '0 : regs_q[rt_addr];
`ifdef WB_BYPASS_EN
    // wb_we already excludes $0, so the bypass can never expose a write to $0
    if (wb_we && (rs_addr == wb_addr)) begin
      rs_data = wb_data;
    end
    if (wb_we && (rt_addr == wb_addr)) begin
      rt_data = wb_data;
    end
`endif
  end

endmodule
`default_nettype wire
